i2s_burst_arbiter: RTL and testbench
====================================

# i2s_burst_arbiter

Parametrised round-robin collector that sits between the per-line I2S receiver FIFOs and the AXI-Stream capture path. It picks the next ready, enabled channel in one cycle, reads a fixed-length burst from that channel's FIFO, and tags each sample with its channel ID. It then delivers the samples through an internal output buffer to an AXI-Stream master port with full `tready` backpressure and a `tlast` per burst.

## Interface
- `CHANNEL_NUM`, 32: number of receiver channels (1..64).
- `ID_WIDTH`, 5: channel-ID field width; 2**ID_WIDTH >= CHANNEL_NUM.
- `SAMPLE_WIDTH`, 16: width of one FIFO word.
- `TDATA_WIDTH`, 32: output width; >= SAMPLE_WIDTH+ID_WIDTH when TAG_ENABLE=1.
- `BURST_LEN`, 15: words read per grant (1..255).
- `OUT_DEPTH`, 4: output buffer entries (power of two, >= 4).
- `TAG_ENABLE`, 1: 1 puts the channel ID in the top ID_WIDTH bits of tdata; 0 leaves those bits zero.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_ready`  in  CHANNEL_NUM  channel FIFO holds >= BURST_LEN words.
- `ch_mask`  in  CHANNEL_NUM  1 = channel eligible for grant.
- `ch_rd_en`  out  CHANNEL_NUM  one-hot read strobe.
- `ch_rdata`  in  CHANNEL_NUM*SAMPLE_WIDTH  flattened FIFO outputs; channel k is at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]. Data is valid the cycle after `ch_rd_en`.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  sink accepts.
- `m_axis_tdata`  out  TDATA_WIDTH  {ID or 0, zeros, sample}.
- `m_axis_tlast`  out  1  last word of a burst.
- `busy`  out  1  a burst is in progress (state BURST).
- `cur_id`  out  ID_WIDTH  ID of the last granted channel.

## Operation
- Reset values: all outputs are 0, `ptr`=0, state is SCAN, the buffer is empty, `inflight`=0.
- **SCAN**
  - Form `req = ch_ready & ch_mask`.
  - If `req` != 0, grant the first set bit at or after `ptr`, wrapping from CHANNEL_NUM-1 to 0.
  - On a grant: register the grant, set `cur_id`, clear the word counter, set `ptr` = grant+1 (wrapping), and go to BURST.
  - If `req` == 0, stay in SCAN; `ptr` is unchanged.
- **BURST**
  - Pulse `ch_rd_en[grant]` in any cycle where `count + inflight < OUT_DEPTH`. `count` is the buffer occupancy before this cycle's pop.
  - Increment the word counter on each pulse.
  - After pulse number BURST_LEN, return to SCAN.
- Read-data capture:
  - `inflight` is set on the cycle of a read and cleared the cycle after.
  - The cycle after a read, write `ch_rdata[grant]`, the tag, and the last flag (counter == BURST_LEN-1 at read time) into the buffer.
- **Output buffer**
  - Synchronous FIFO; the head drives the m_axis signals.
  - Pop on `tvalid & tready`.
  - A simultaneous push and pop leaves `count` unchanged.
  - Credit gating means the buffer never overflows.
- Data format:
  - `tdata[SAMPLE_WIDTH-1:0]` = sample.
  - `tdata[TDATA_WIDTH-1 -: ID_WIDTH]` = ID when TAG_ENABLE=1.
  - All other bits are 0.
- Boundaries:
  - `ch_ready` or `ch_mask` dropping mid-burst is ignored; the burst always completes.
  - A new grant may be issued while earlier words are still buffered; ordering is preserved.
  - The grant pointer wraps from channel CHANNEL_NUM-1 to 0.
  - If `rst_n` is asserted mid-burst, everything clears at once and the partial burst is discarded.
  - tvalid/tdata hold stable while tready is low.

## Timing
- SCAN grant at cycle t: first `ch_rd_en` at t+1, buffer write at t+2, `m_axis_tvalid` at t+3 (first word, empty buffer).
- With tready held high, sustained throughput is 1 word/cycle. A burst occupies BURST_LEN cycles of BURST plus 1 SCAN cycle.
- Back-to-back bursts to different channels have a 1-cycle gap (SCAN) on `ch_rd_en`.
- When tready is low, reads stop after the buffer plus in-flight entries reach OUT_DEPTH. They resume the cycle after a pop.

## Test plan
- Channel 3 only ready, mask all ones, BURST_LEN=15, tready=1, ch_rdata[3] increments from 0x0100:
  - exactly 15 words out, 0x0100..0x010E;
  - tdata[31:27]=3;
  - tlast on word 15 only;
  - `busy` low after.
- Channels 0, 5, 31 all ready continuously: grant order is 0, 5, 31, 0, … and the pointer wraps past 31.
- Channel 5 ready, ch_mask[5]=0: no `ch_rd_en` and no output. Set mask bit 5: the burst starts 1 cycle later.
- tready=0 throughout a burst: exactly OUT_DEPTH `ch_rd_en` pulses, tdata stable. Release tready: all 15 words arrive in order, no loss or duplication.
- Random tready at 50% over 1000 bursts on random channels: the scoreboard matches per-channel sequence and ID, and every group of 15 words ends in tlast.
- Assert `rst_n` low at word 7 of a burst: all outputs are 0 asynchronously. After release, the next grant starts from channel 0 with a fresh 15-word count.

Source files
------------

// File: rtl/i2s_burst_arbiter.sv
// Round-robin burst collector: grants one ready, enabled I2S channel at a time, reads a
// fixed-length burst from its FIFO and streams channel-tagged samples out over AXI-Stream.
module i2s_burst_arbiter #(
  parameter int CHANNEL_NUM  = 32,
  parameter int ID_WIDTH     = 5,
  parameter int SAMPLE_WIDTH = 16,
  parameter int TDATA_WIDTH  = 32,
  parameter int BURST_LEN    = 15,
  parameter int OUT_DEPTH    = 4,
  parameter int TAG_ENABLE   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNEL_NUM-1:0]              ch_ready,
  input  logic [CHANNEL_NUM-1:0]              ch_mask,
  output logic [CHANNEL_NUM-1:0]              ch_rd_en,
  input  logic [CHANNEL_NUM*SAMPLE_WIDTH-1:0] ch_rdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [TDATA_WIDTH-1:0]              m_axis_tdata,
  output logic                                m_axis_tlast,
  output logic                                busy,
  output logic [ID_WIDTH-1:0]                 cur_id
);

  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int EW = TDATA_WIDTH + 1;

  typedef enum logic {SCAN, BURST} state_t;

  state_t                  state, next_state;
  logic [CHANNEL_NUM-1:0]  req;
  logic [ID_WIDTH-1:0]     ptr, grant_id, search_id;
  logic                    search_hit;
  logic [7:0]              word_cnt;
  logic                    last_read, rd_pulse;
  logic                    inflight, inflight_last;
  logic [AW:0]             count;
  logic [AW+1:0]           credit_used;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [EW-1:0]           mem [OUT_DEPTH];
  logic [EW-1:0]           head;
  logic                    push, pop;
  logic [SAMPLE_WIDTH-1:0] ch_sample [CHANNEL_NUM];
  logic [TDATA_WIDTH-1:0]  push_data;

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_split
    assign ch_sample[k] = ch_rdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  assign req = ch_ready & ch_mask;

  // First requesting channel at or after ptr, wrapping around the channel range.
  always_comb begin : grant_search
    int idx;
    idx        = 0;
    search_hit = 1'b0;
    search_id  = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
      if (!search_hit && req[CW'(idx)]) begin
        search_hit = 1'b1;
        search_id  = ID_WIDTH'(idx);
      end
    end
  end

  // Reads are credit-gated: buffered words plus the one in flight may never exceed the buffer.
  assign credit_used = {1'b0, count} + (AW+2)'(inflight);
  assign rd_pulse    = (state == BURST) && (credit_used < (AW+2)'(OUT_DEPTH));
  assign last_read   = (word_cnt == 8'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SCAN:    if (search_hit) next_state = BURST;
      BURST:   if (rd_pulse && last_read) next_state = SCAN;
      default: next_state = SCAN;
    endcase
  end

  always_comb begin
    busy     = (state == BURST);
    ch_rd_en = '0;
    if (rd_pulse) ch_rd_en[CW'(grant_id)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant_id <= '0;
      word_cnt <= '0;
    end else if (state == SCAN && search_hit) begin
      grant_id <= search_id;
      word_cnt <= '0;
      if (search_id == ID_WIDTH'(CHANNEL_NUM - 1)) ptr <= '0;
      else                                          ptr <= search_id + 1'b1;
    end else if (rd_pulse) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  assign cur_id = grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_pulse;
      inflight_last <= rd_pulse && last_read;
    end
  end

  // grant_id is still the reading channel here: a new grant lands on the same edge as this push.
  always_comb begin
    push_data                     = '0;
    push_data[SAMPLE_WIDTH-1:0]   = ch_sample[CW'(grant_id)];
    if (TAG_ENABLE != 0) push_data[TDATA_WIDTH-1 -: ID_WIDTH] = grant_id;
  end

  assign push = inflight;
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {inflight_last, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[TDATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[TDATA_WIDTH];

endmodule

// File: tb/tb_i2s_burst_arbiter.sv
// Scoreboard bench for i2s_burst_arbiter: a FIFO/round-robin model predicts every word,
// a negedge monitor pops predictions as the AXI-Stream port delivers.
module tb_i2s_burst_arbiter;
  localparam int CH  = 32;
  localparam int IDW = 5;
  localparam int SW  = 16;
  localparam int TW  = 32;
  localparam int BL  = 15;
  localparam int OD  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     ch_ready = '0;
  logic [CH-1:0]     ch_mask = '1;
  logic [CH-1:0]     ch_rd_en;
  logic [CH*SW-1:0]  ch_rdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [TW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              busy;
  logic [IDW-1:0]    cur_id;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [SW-1:0] cnt [CH] = '{default: '0};
  logic [SW-1:0] rdata_mem [CH];

  logic [TW:0]   exp_q [$];
  int            grant_log [$];
  int            grant_cycle [$];
  int            burst_ch = -1;
  int            reads_in_burst = 0;
  int            rr_ptr = 0;
  int            bursts = 0;
  int            rd_pulses = 0;
  int            pops = 0;
  int            tlasts = 0;
  logic [CH-1:0] prev_req = '0;
  logic          prev_busy = 1'b0;
  logic          prev_stall = 1'b0;
  logic [TW-1:0] prev_tdata = '0;
  logic          prev_tlast = 1'b0;

  i2s_burst_arbiter #(
    .CHANNEL_NUM(CH), .ID_WIDTH(IDW), .SAMPLE_WIDTH(SW), .TDATA_WIDTH(TW),
    .BURST_LEN(BL), .OUT_DEPTH(OD), .TAG_ENABLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_ready(ch_ready), .ch_mask(ch_mask),
    .ch_rd_en(ch_rd_en), .ch_rdata(ch_rdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [SW-1:0] base_of(input int k);
    if (k == 3) return 16'h0100;
    return SW'((k << 11) | 32'h40);
  endfunction

  function automatic int rr_pick(input logic [CH-1:0] r, input int p);
    int c;
    for (int i = 0; i < CH; i++) begin
      c = (p + i) % CH;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  // Channel FIFO model: registered output, garbage whenever the channel is not being read.
  always @(posedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (ch_rd_en[k]) begin
        rdata_mem[k] <= base_of(k) + cnt[k];
        cnt[k]       <= cnt[k] + 1'b1;
      end else begin
        rdata_mem[k] <= SW'($urandom);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) ch_rdata[k*SW +: SW] = rdata_mem[k];
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: predicts grants and words from the request history, checks every delivered word.
  always @(negedge clk) begin
    int exp_ch;
    logic [TW:0] e;
    if (!rst_n) begin
      exp_q.delete();
      burst_ch       = -1;
      reads_in_burst = 0;
      rr_ptr         = 0;
      prev_busy      = 1'b0;
      prev_stall     = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        exp_ch = rr_pick(prev_req, rr_ptr);
        check_output("grant_id", 64'(cur_id), 64'(exp_ch));
        burst_ch       = exp_ch;
        reads_in_burst = 0;
        if (exp_ch >= 0) rr_ptr = (exp_ch + 1) % CH;
        bursts++;
        grant_log.push_back(exp_ch);
        grant_cycle.push_back(cycle);
      end
      if (!busy && prev_busy) check_output("burst_len", 64'(reads_in_burst), 64'(BL));
      if (ch_rd_en != '0) begin
        rd_pulses++;
        check_output("rd_en", 64'(ch_rd_en), (busy && burst_ch >= 0) ? (64'd1 << burst_ch) : 64'd0);
        if (burst_ch >= 0) begin
          exp_q.push_back({reads_in_burst == BL - 1,
                           (TW'(burst_ch) << (TW - IDW)) | TW'(base_of(burst_ch) + cnt[burst_ch])});
          reads_in_burst++;
          check_output("credit", 64'(exp_q.size() <= OD), 64'd1);
        end
      end
      if (prev_stall) begin
        check_output("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        check_output("hold_tdata", 64'(m_axis_tdata), 64'(prev_tdata));
        check_output("hold_tlast", 64'(m_axis_tlast), 64'(prev_tlast));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        pops++;
        if (m_axis_tlast) tlasts++;
        check_output("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_output("tdata", 64'(m_axis_tdata), 64'(e[TW-1:0]));
          check_output("tlast", 64'(m_axis_tlast), 64'(e[TW]));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      prev_tlast = m_axis_tlast;
      prev_busy  = busy;
    end
    prev_req = ch_ready & ch_mask;
  end

  task automatic apply_stimulus(input logic [CH-1:0] ready, input logic [CH-1:0] mask, input logic tready);
    @(posedge clk); #1;
    ch_ready      = ready;
    ch_mask       = mask;
    m_axis_tready = tready;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || m_axis_tvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_output({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    check_output({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
    check_output({tag, "_rd_en"},  64'(ch_rd_en),      64'd0);
    check_output({tag, "_busy"},   64'(busy),          64'd0);
    check_output({tag, "_cur_id"}, 64'(cur_id),        64'd0);
  endtask

  initial begin
    int p0, t0, r0, g0, b0, n;
    int exp_order [6] = '{0, 5, 31, 0, 5, 31};

    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single channel 3 burst with first-word latency.
    p0 = pops; t0 = tlasts;
    ch_ready = 32'h8; ch_mask = '1; m_axis_tready = 1'b1;
    @(negedge clk);
    check_output("t0_rd_en", 64'(ch_rd_en), 64'd0);
    @(negedge clk);
    check_output("t1_rd_en", 64'(ch_rd_en), 64'h8);
    check_output("t1_busy", 64'(busy), 64'd1);
    apply_stimulus('0, '1, 1'b1);
    @(negedge clk);
    check_output("t2_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check_output("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_output("t3_tdata", 64'(m_axis_tdata), 64'h1800_0100);
    wait_drain(200);
    check_output("ch3_words", 64'(pops - p0), 64'(BL));
    check_output("ch3_tlasts", 64'(tlasts - t0), 64'd1);
    check_output("ch3_busy_after", 64'(busy), 64'd0);

    // Masked channel stays silent until its mask bit is set.
    r0 = rd_pulses; p0 = pops;
    apply_stimulus(32'h20, ~32'h20, 1'b1);
    repeat (20) @(negedge clk);
    check_output("masked_reads", 64'(rd_pulses - r0), 64'd0);
    check_output("masked_words", 64'(pops - p0), 64'd0);
    apply_stimulus(32'h20, '1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_output("unmask_rd_en", 64'(ch_rd_en), 64'h20);
    apply_stimulus('0, '1, 1'b1);
    wait_drain(200);

    // Round-robin order over channels 0, 5, 31 with pointer wrap.
    apply_reset();
    g0 = grant_log.size(); n = 0;
    ch_ready = 32'h8000_0021;
    while (grant_log.size() < g0 + 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    apply_stimulus('0, '1, 1'b1);
    check_output("rr_in_time", 64'(n < 300), 64'd1);
    if (grant_log.size() >= g0 + 6) begin
      for (int i = 0; i < 6; i++) begin
        check_output("rr_order", 64'(grant_log[g0+i]), 64'(exp_order[i]));
        if (i > 0) check_output("rr_spacing", 64'(grant_cycle[g0+i] - grant_cycle[g0+i-1]), 64'(BL + 1));
      end
    end
    wait_drain(200);

    // Backpressure: reads stop at OD credits, data holds, nothing lost on release.
    r0 = rd_pulses; p0 = pops; t0 = tlasts;
    apply_stimulus(32'h80, '1, 1'b0);
    apply_stimulus('0, '1, 1'b0);
    repeat (40) @(negedge clk);
    check_output("stall_reads", 64'(rd_pulses - r0), 64'(OD));
    check_output("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
    apply_stimulus('0, '1, 1'b1);
    wait_drain(200);
    check_output("stall_words", 64'(pops - p0), 64'(BL));
    check_output("stall_tlasts", 64'(tlasts - t0), 64'd1);

    // Random traffic and backpressure.
    b0 = bursts; n = 0;
    while (bursts - b0 < 1000 && n < 60000) begin
      apply_stimulus($urandom & $urandom, $urandom | $urandom, 1'($urandom_range(0, 1)));
      n++;
    end
    check_output("random_bursts", 64'(bursts - b0 >= 1000), 64'd1);
    apply_stimulus('0, '1, 1'b1);
    wait_drain(200);

    // Reset in the middle of a burst.
    apply_stimulus(32'h200, '1, 1'b1);
    n = 0;
    while (!(busy && reads_in_burst >= 7) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_burst_reached", 64'(n < 200), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    ch_ready = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = pops; t0 = tlasts; g0 = grant_log.size(); n = 0;
    ch_ready = 32'h201;
    while (grant_log.size() <= g0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    apply_stimulus('0, '1, 1'b1);
    check_output("post_reset_grant_in_time", 64'(n < 50), 64'd1);
    if (grant_log.size() > g0) check_output("post_reset_grant", 64'(grant_log[g0]), 64'd0);
    wait_drain(200);
    check_output("post_reset_words", 64'(pops - p0), 64'(BL));
    check_output("post_reset_tlasts", 64'(tlasts - t0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
